// File: rtl/mistral_mac_pipe_if.sv
// Operand/result bundle for the registered Mistral DSP multiply-accumulate pipe.
// The master drives operands and observes the accumulator; the slave is the pipe.
interface mistral_mac_pipe_if #(
    parameter int A_WIDTH = 27,
    parameter int B_WIDTH = 27,
    parameter int Y_WIDTH = 64
) ();
    logic               IN_VALID;
    logic [A_WIDTH-1:0] A;
    logic [B_WIDTH-1:0] B;
    logic               ACC;
    logic               OUT_VALID;
    logic [Y_WIDTH-1:0] Y;
    logic               OVF;

    modport master (
        output IN_VALID, A, B, ACC,
        input  OUT_VALID, Y, OVF
    );

    modport slave (
        input  IN_VALID, A, B, ACC,
        output OUT_VALID, Y, OVF
    );
endinterface

// File: rtl/mistral_mac_pipe.sv
// Three-stage registered multiply-accumulate around a MISTRAL_MUL27X27/18X18 cell:
// operand registers, product register, then load-or-accumulate into a wide Y with sticky overflow.
module mistral_mac_pipe #(
    parameter int A_WIDTH  = 27,
    parameter int B_WIDTH  = 27,
    parameter bit A_SIGNED = 1'b1,
    parameter bit B_SIGNED = 1'b1,
    parameter int Y_WIDTH  = 64
) (
    input  logic                  CLK,
    input  logic                  SCLR,
    input  logic                  ENA,
    mistral_mac_pipe_if.slave     bus
);
    localparam int P_W = A_WIDTH + B_WIDTH;
    // Mixed signedness degrades to an unsigned product, as in Verilog expressions.
    localparam bit SGN = A_SIGNED && B_SIGNED;

    generate
        if (Y_WIDTH < P_W) begin : g_bad_width
            $error("mistral_mac_pipe: Y_WIDTH must be >= A_WIDTH+B_WIDTH");
        end
    endgenerate

    function automatic logic [Y_WIDTH-1:0] ext_y(input logic [P_W-1:0] p);
        logic [Y_WIDTH-1:0] r;
        r = '0;
        r[P_W-1:0] = p;
        for (int i = P_W; i < Y_WIDTH; i++) r[i] = SGN & p[P_W-1];
        return r;
    endfunction

    function automatic logic ovf_chk(input logic [Y_WIDTH-1:0] x,
                                     input logic [Y_WIDTH-1:0] e,
                                     input logic [Y_WIDTH:0]   s);
        if (SGN)
            return (x[Y_WIDTH-1] == e[Y_WIDTH-1]) && (s[Y_WIDTH-1] != x[Y_WIDTH-1]);
        return s[Y_WIDTH];
    endfunction

    logic [A_WIDTH-1:0] a_p0;
    logic [B_WIDTH-1:0] b_p0;
    logic               acc_p0, vld_p0;
    logic [P_W-1:0]     prod_p1;
    logic               acc_p1, vld_p1;
    logic [Y_WIDTH-1:0] y_p2;
    logic               ovf_p2, vld_p2;

    logic [P_W-1:0]     a_x, b_x;
    logic [Y_WIDTH-1:0] prod_ext;
    logic [Y_WIDTH:0]   sum;

    // Low P_W bits of the product are identical for signed and unsigned once extended.
    assign a_x      = {{B_WIDTH{SGN & a_p0[A_WIDTH-1]}}, a_p0};
    assign b_x      = {{A_WIDTH{SGN & b_p0[B_WIDTH-1]}}, b_p0};
    assign prod_ext = ext_y(prod_p1);
    assign sum      = {1'b0, y_p2} + {1'b0, prod_ext};

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            a_p0    <= '0;
            b_p0    <= '0;
            acc_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            prod_p1 <= '0;
            acc_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            y_p2    <= '0;
            ovf_p2  <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (ENA) begin
            // stage 0: operand capture
            a_p0    <= bus.A;
            b_p0    <= bus.B;
            acc_p0  <= bus.ACC;
            vld_p0  <= bus.IN_VALID;
            // stage 1: product register
            prod_p1 <= a_x * b_x;
            acc_p1  <= acc_p0;
            vld_p1  <= vld_p0;
            // stage 2: accumulator
            vld_p2  <= vld_p1;
            if (vld_p1) begin
                if (acc_p1) begin
                    y_p2   <= sum[Y_WIDTH-1:0];
                    ovf_p2 <= ovf_p2 | ovf_chk(y_p2, prod_ext, sum);
                end else begin
                    y_p2   <= prod_ext;
                    ovf_p2 <= 1'b0;
                end
            end
        end
    end

    assign bus.OUT_VALID = vld_p2;
    assign bus.Y         = y_p2;
    assign bus.OVF       = ovf_p2;
endmodule

// File: tb/tb_mistral_mac_pipe.sv
// Directed bench: a signed 27x27->64 pipe and an unsigned 27x27->54 pipe sharing clock, reset and enable.
module tb_mistral_mac_pipe;
    logic CLK = 1'b0;
    logic SCLR, ENA;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    mistral_mac_pipe_if #(.A_WIDTH(27), .B_WIDTH(27), .Y_WIDTH(64)) sb ();
    mistral_mac_pipe_if #(.A_WIDTH(27), .B_WIDTH(27), .Y_WIDTH(54)) ub ();

    mistral_mac_pipe #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .Y_WIDTH(64))
        u_s (.CLK(CLK), .SCLR(SCLR), .ENA(ENA), .bus(sb));
    mistral_mac_pipe #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(1'b0), .B_SIGNED(1'b1), .Y_WIDTH(54))
        u_u (.CLK(CLK), .SCLR(SCLR), .ENA(ENA), .bus(ub));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv_s(input logic v, input logic [26:0] a, input logic [26:0] b, input logic acc);
        sb.IN_VALID = v; sb.A = a; sb.B = b; sb.ACC = acc;
    endtask

    task automatic drv_u(input logic v, input logic [26:0] a, input logic [26:0] b, input logic acc);
        ub.IN_VALID = v; ub.A = a; ub.B = b; ub.ACC = acc;
    endtask

    logic [63:0] exp_u [4];
    logic        exp_uo [4];
    logic [26:0] ua [4];
    logic [26:0] ub_op [4];
    logic        uacc [4];

    initial begin
        ENA  = 1'b1;
        SCLR = 1'b1;
        // Reset with valid, randomised operands present: nothing may leak through.
        for (int i = 0; i < 2; i++) begin
            drv_s(1'b1, 27'($urandom), 27'($urandom), 1'b1);
            drv_u(1'b1, 27'($urandom), 27'($urandom), 1'b1);
            tick();
            check("rst_y", sb.Y, 64'd0);
            check("rst_ovf", 64'(sb.OVF), 64'd0);
            check("rst_vld", 64'(sb.OUT_VALID), 64'd0);
            check("rst_u_y", 64'(ub.Y), 64'd0);
        end
        SCLR = 1'b0;
        drv_s(1'b0, '0, '0, 1'b0);
        drv_u(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_vld", 64'(sb.OUT_VALID), 64'd0);
            check("idle_y", sb.Y, 64'd0);
        end

        // Signed load of -3*5: visible exactly on the third edge.
        drv_s(1'b1, 27'h7FFFFFD, 27'd5, 1'b0);
        tick();
        drv_s(1'b0, '0, '0, 1'b0);
        tick();
        check("lat_e2_vld", 64'(sb.OUT_VALID), 64'd0);
        tick();
        check("lat_e3_vld", 64'(sb.OUT_VALID), 64'd1);
        check("neg15_y", sb.Y, 64'hFFFF_FFFF_FFFF_FFF1);
        tick();
        check("after_vld", 64'(sb.OUT_VALID), 64'd0);
        check("hold_y", sb.Y, 64'hFFFF_FFFF_FFFF_FFF1);

        // Back-to-back accumulation of 1000*1000.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drv_s(1'b1, 27'd1000, 27'd1000, k != 0);
            else       drv_s(1'b0, '0, '0, 1'b0);
            tick();
            if (k >= 2) begin
                check("accum_vld", 64'(sb.OUT_VALID), 64'd1);
                check("accum_y", sb.Y, 64'(k - 1) * 64'd1000000);
                check("accum_ovf", 64'(sb.OVF), 64'd0);
            end
        end
        drv_s(1'b0, '0, '0, 1'b0);
        tick();
        tick();

        // Unsigned 54-bit: full-scale load, wrapping accumulate, sticky hold, clearing load.
        ua[0] = 27'h7FFFFFF; ub_op[0] = 27'h7FFFFFF; uacc[0] = 1'b0; exp_u[0] = 64'h003F_FFFF_F000_0001; exp_uo[0] = 1'b0;
        ua[1] = 27'h7FFFFFF; ub_op[1] = 27'h7FFFFFF; uacc[1] = 1'b1; exp_u[1] = 64'h003F_FFFF_E000_0002; exp_uo[1] = 1'b1;
        ua[2] = 27'd0;       ub_op[2] = 27'd0;       uacc[2] = 1'b1; exp_u[2] = 64'h003F_FFFF_E000_0002; exp_uo[2] = 1'b1;
        ua[3] = 27'd2;       ub_op[3] = 27'd3;       uacc[3] = 1'b0; exp_u[3] = 64'd6;                   exp_uo[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drv_u(1'b1, ua[k], ub_op[k], uacc[k]);
            else       drv_u(1'b0, '0, '0, 1'b0);
            tick();
            if (k >= 2) begin
                check("uns_vld", 64'(ub.OUT_VALID), 64'd1);
                check("uns_y", 64'(ub.Y), exp_u[k-2]);
                check("uns_ovf", 64'(ub.OVF), 64'(exp_uo[k-2]));
            end
        end
        drv_u(1'b0, '0, '0, 1'b0);
        tick();
        tick();

        // ENA stall with two beats still in flight; a valid beat offered while stalled must be ignored.
        for (int i = 0; i < 3; i++) begin
            drv_s(1'b1, 27'(i + 1), 27'd7, 1'b0);
            tick();
        end
        check("stall_pre_vld", 64'(sb.OUT_VALID), 64'd1);
        check("stall_pre_y", sb.Y, 64'd7);
        ENA = 1'b0;
        drv_s(1'b1, 27'd99, 27'd99, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_vld", 64'(sb.OUT_VALID), 64'd1);
            check("stall_y", sb.Y, 64'd7);
        end
        ENA = 1'b1;
        drv_s(1'b0, '0, '0, 1'b0);
        tick();
        check("resume1_vld", 64'(sb.OUT_VALID), 64'd1);
        check("resume1_y", sb.Y, 64'd14);
        tick();
        check("resume2_vld", 64'(sb.OUT_VALID), 64'd1);
        check("resume2_y", sb.Y, 64'd21);
        tick();
        check("resume3_vld", 64'(sb.OUT_VALID), 64'd0);
        tick();
        check("resume4_vld", 64'(sb.OUT_VALID), 64'd0);
        check("resume4_y", sb.Y, 64'd21);

        // SCLR with two beats in flight discards both.
        drv_s(1'b1, 27'd5, 27'd5, 1'b0);
        tick();
        drv_s(1'b1, 27'd6, 27'd6, 1'b0);
        tick();
        SCLR = 1'b1;
        drv_s(1'b0, '0, '0, 1'b0);
        tick();
        SCLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_vld", 64'(sb.OUT_VALID), 64'd0);
            check("flush_y", sb.Y, 64'd0);
        end
        drv_s(1'b1, 27'd2, 27'd2, 1'b0);
        tick();
        drv_s(1'b0, '0, '0, 1'b0);
        tick();
        check("post_e2_vld", 64'(sb.OUT_VALID), 64'd0);
        tick();
        check("post_e3_vld", 64'(sb.OUT_VALID), 64'd1);
        check("post_y", sb.Y, 64'd4);
        check("post_ovf", 64'(sb.OVF), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
